// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Brief    : Matrix keypad scanner with frame-based debounce and a small
//            first-word-fall-through code queue with sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo #(
  parameter int ROWS       = 5,
  parameter int COLS       = 4,
  parameter int CODE_W     = 5,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   k_col,
  output logic [ROWS-1:0]   k_row,
  input  logic              rd_n,
  output logic [CODE_W-1:0] key_code,
  output logic              rdy,
  output logic              key_held,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = $clog2(DEB_FRAMES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } deb_state_t;

  // ---------------- scan divider / row walker ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             sample;
  logic             frame_end;

  // Divider wraps every SCAN_DIV cycles; the row advances right after its sample.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (row_q == ROW_LAST);
    div_d     = sample ? '0 : div_q + DIV_W'(1);
    row_d     = row_q;
    if (sample) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    end
  end

  assign k_row = ~(ROWS'(1) << row_q);

  // ---------------- per-row column decode ----------------
  logic [1:0]       row_hits;
  logic [COL_W-1:0] row_col;

  // Count closed columns on the driven row (saturating at 2) and locate one of them.
  always_comb begin
    row_hits = 2'd0;
    row_col  = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!k_col[c]) begin
        row_col = COL_W'(c);
        if (row_hits != 2'd2) begin
          row_hits = row_hits + 2'd1;
        end
      end
    end
  end

  // ---------------- frame accumulator ----------------
  logic [1:0]        hits_q, hits_d, frame_hits;
  logic [2:0]        hits_sum;
  logic [CODE_W-1:0] fcode_q, fcode_d, frame_code, row_code;

  // Merge each row sample into the running frame result; clear at frame end.
  always_comb begin
    row_code   = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(row_col);
    hits_sum   = {1'b0, hits_q} + {1'b0, row_hits};
    frame_hits = hits_q;
    frame_code = fcode_q;
    if (sample) begin
      frame_hits = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
      if (row_hits == 2'd1) begin
        frame_code = row_code;
      end
    end
    hits_d  = frame_end ? 2'd0 : frame_hits;
    fcode_d = frame_end ? '0 : frame_code;
  end

  // ---------------- debounce FSM ----------------
  deb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] push_code;
  logic              push;
  logic              f_none, f_one;

  // Evaluate the completed frame once per frame end; push on accepted press.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    push      = 1'b0;
    push_code = cand_q;
    f_none    = (frame_hits == 2'd0);
    f_one     = (frame_hits == 2'd1);
    cnt_inc   = cnt_q + CNT_W'(1);
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (f_one) begin
            cand_d = frame_code;
            if (CNT_DONE == CNT_ONE) begin
              push      = 1'b1;
              push_code = frame_code;
              state_d   = S_HELD;
              cnt_d     = '0;
            end else begin
              state_d = S_PRESS_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_PRESS_CHK: begin
          if (f_one && (frame_code == cand_q)) begin
            if (cnt_inc == CNT_DONE) begin
              push    = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          // Any non-empty frame keeps the key held; no auto-repeat.
          if (f_none) begin
            if (CNT_DONE == CNT_ONE) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_REL_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_REL_CHK: begin
          if (f_none) begin
            if (cnt_inc == CNT_DONE) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign key_held = (state_q == S_HELD) || (state_q == S_REL_CHK);

  // ---------------- FIFO ----------------
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CODE_W-1:0] head_q, head_d;
  logic              ovf_q, ovf_d;
  logic              empty, full, pop, wr_en, ovf_set;

  // Pointer/flag update; the head register tracks the entry at the next read pointer.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop     = !rd_n && !empty;
    wr_en   = push && (!full || pop);
    ovf_set = push && full && !pop;
    wr_d    = wr_en ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
    head_d  = head_q;
    if (rd_d != wr_d) begin
      // The new head may be the word being written this very cycle.
      if (wr_en && (rd_d == wr_q)) begin
        head_d = push_code;
      end else begin
        head_d = mem_q[rd_d[AW-1:0]];
      end
    end
    // A fresh overflow beats a simultaneous clear.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Queue storage needs no reset: validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= push_code;
    end
  end

  // State registers for scanner, debouncer and queue control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      row_q   <= '0;
      hits_q  <= 2'd0;
      fcode_q <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      row_q   <= row_d;
      hits_q  <= hits_d;
      fcode_q <= fcode_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key_code = head_q;
  assign rdy      = !empty;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_fifo
// Brief    : Directed self-checking bench for keypad_scan_fifo
//            (5x4 keypad, 4-cycle row slot, 3-frame debounce, 4-deep queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] k_col;
  logic [4:0] k_row;
  logic       rd_n;
  logic [4:0] key_code;
  logic       rdy;
  logic       key_held;
  logic       overflow;
  logic       clr_ovf;
  logic [19:0] pressed;

  int vectors    = 0;
  int miscompares = 0;

  keypad_scan_fifo #(
    .ROWS(5), .COLS(4), .CODE_W(5), .SCAN_DIV(4), .DEB_FRAMES(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .k_col(k_col), .k_row(k_row), .rd_n(rd_n),
    .key_code(key_code), .rdy(rdy), .key_held(key_held), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    k_col = 4'b1111;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (!k_row[r] && pressed[r*4+c]) k_col[c] = 1'b0;
  end

  // Advance to the first cycle of the next scan frame (row 0 just driven).
  task automatic next_frame();
    int n;
    n = 0;
    while (k_row !== 5'b01111 && n < 60) begin @(negedge clk); n++; end
    while (k_row !== 5'b11110 && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      vectors++; miscompares++;
      $display("FAIL frame_sync: no frame boundary in 60 cycles, k_row=%b", k_row);
    end
  endtask

  task automatic hold_frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
  endtask

  // Press one key long enough to be accepted, then release it fully.
  task automatic tap_key(input int code);
    pressed = 20'd0;
    pressed[code] = 1'b1;
    hold_frames(3);
    pressed = 20'd0;
    hold_frames(3);
  endtask

  task automatic test_reset();
    logic [4:0] exp_row;
    rst = 1'b1; rd_n = 1'b1; clr_ovf = 1'b0; pressed = 20'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (k_row !== 5'b11110) begin miscompares++; $display("FAIL reset_k_row: got %b want 11110", k_row); end
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", key_held); end
    vectors++; if (key_code !== 5'd0) begin miscompares++; $display("FAIL reset_code: got %0d want 0", key_code); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_row = ~(5'b00001 << (i / 4));
      vectors++;
      if (k_row !== exp_row) begin
        miscompares++;
        $display("FAIL row_walk[%0d]: got %b want %b", i, k_row, exp_row);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_press();
    next_frame();
    pressed = 20'd0; pressed[9] = 1'b1;
    hold_frames(2);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL press_early_rdy: got %b want 0", rdy); end
    hold_frames(1);
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL press_rdy: got %b want 1", rdy); end
    vectors++; if (key_code !== 5'd9) begin miscompares++; $display("FAIL press_code: got %0d want 9", key_code); end
    vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL press_held: got %b want 1", key_held); end
    hold_frames(3);
    pressed = 20'd0;
    rd_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1;
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL press_single_push: rdy got %b want 0", rdy); end
    vectors++; if (key_code !== 5'd9) begin miscompares++; $display("FAIL press_code_hold: got %0d want 9", key_code); end
    hold_frames(2);
    vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL release_early: held got %b want 1", key_held); end
    hold_frames(1);
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL release_held: got %b want 0", key_held); end
  endtask

  task automatic test_bounce();
    pressed = 20'd0; pressed[6] = 1'b1;
    hold_frames(2);
    pressed = 20'd0;
    hold_frames(1);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL bounce_rdy: got %b want 0", rdy); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL bounce_held: got %b want 0", key_held); end
    hold_frames(3);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL bounce_late_rdy: got %b want 0", rdy); end
  endtask

  task automatic test_multi_key();
    pressed = 20'd0; pressed[0] = 1'b1; pressed[14] = 1'b1;
    hold_frames(5);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL multi_rdy: got %b want 0", rdy); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL multi_held: got %b want 0", key_held); end
    pressed[14] = 1'b0;
    hold_frames(2);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL multi_drop_early: rdy got %b want 0", rdy); end
    hold_frames(1);
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL multi_drop_rdy: got %b want 1", rdy); end
    vectors++; if (key_code !== 5'd0) begin miscompares++; $display("FAIL multi_drop_code: got %0d want 0", key_code); end
    pressed = 20'd0;
    rd_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1;
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL multi_pop: rdy got %b want 0", rdy); end
    hold_frames(3);
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL multi_release: held got %b want 0", key_held); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      pressed = 20'd0; pressed[k] = 1'b1;
      hold_frames(3);
      vectors++;
      if (overflow !== (k == 5)) begin
        miscompares++;
        $display("FAIL ovf_after_push%0d: got %b want %b", k, overflow, (k == 5));
      end
      pressed = 20'd0;
      hold_frames(3);
    end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL ovf_released: held got %b want 0", key_held); end
    // Hold rd_n low: one entry per cycle.
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rdy !== 1'b1 || key_code !== 5'(i + 1)) begin
        miscompares++;
        $display("FAIL ovf_pop%0d: rdy=%b code=%0d want rdy=1 code=%0d", i, rdy, key_code, i + 1);
      end
      rd_n = 1'b0;
      @(negedge clk);
    end
    rd_n = 1'b1;
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: rdy got %b want 0", rdy); end
    vectors++; if (key_code !== 5'd4) begin miscompares++; $display("FAIL ovf_code_hold: got %0d want 4", key_code); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    int n;
    logic [4:0] exp_q [4];
    for (int k = 16; k <= 19; k++) tap_key(k);
    pressed = 20'd0; pressed[7] = 1'b1;
    hold_frames(2);
    n = 0;
    while (k_row !== 5'b01111 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin vectors++; miscompares++; $display("FAIL full_sync: row 4 not reached, k_row=%b", k_row); end
    repeat (3) @(negedge clk);
    rd_n = 1'b0;
    @(negedge clk);
    rd_n = 1'b1;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
    vectors++; if (key_held !== 1'b1) begin miscompares++; $display("FAIL full_pp_held: got %b want 1", key_held); end
    exp_q[0] = 5'd17; exp_q[1] = 5'd18; exp_q[2] = 5'd19; exp_q[3] = 5'd7;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rdy !== 1'b1 || key_code !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_pp_pop%0d: rdy=%b code=%0d want rdy=1 code=%0d", i, rdy, key_code, exp_q[i]);
      end
      rd_n = 1'b0;
      @(negedge clk);
    end
    rd_n = 1'b1;
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL full_pp_drained: rdy got %b want 0", rdy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_pp_ovf_end: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_queue();
    pressed = 20'd0;
    hold_frames(3);
    pressed[5] = 1'b1;
    hold_frames(3);
    vectors++; if (rdy !== 1'b1 || key_code !== 5'd5) begin miscompares++; $display("FAIL rq_pre: rdy=%b code=%0d want 1/5", rdy, key_code); end
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL rq_rdy: got %b want 0", rdy); end
    vectors++; if (key_code !== 5'd0) begin miscompares++; $display("FAIL rq_code: got %0d want 0", key_code); end
    vectors++; if (key_held !== 1'b0) begin miscompares++; $display("FAIL rq_held: got %b want 0", key_held); end
    vectors++; if (k_row !== 5'b11110) begin miscompares++; $display("FAIL rq_k_row: got %b want 11110", k_row); end
    pressed = 20'd0;
    @(negedge clk);
    rst = 1'b0;
    hold_frames(1);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL rq_queue_flushed: rdy got %b want 0", rdy); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_queue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
